// File: rtl/arbitro_memoria_if.sv
// Bundle between the fetch stage, the load/store stage, the unified memory
// and the arbiter that sequences their accesses.
interface arbitro_memoria_if;
  // Handshake: a requester raises *_req with its address/data/direction
  // stable and keeps them so until it sees the matching one-cycle *_ack;
  // a req still high once the arbiter is idle again is a fresh request.
  logic        busca_req;
  logic [31:0] busca_end;
  logic        busca_ack;
  logic [31:0] busca_dado;

  logic        dado_req;
  logic        dado_escrita_en;
  logic [31:0] dado_end;
  logic [31:0] dado_wdata;
  logic        dado_ack;
  logic [31:0] dado_rdata;

  logic [31:0] mem_endereco;
  logic [31:0] mem_dado_escrita;
  logic        mem_leitura;
  logic        mem_escrita;
  logic [31:0] mem_instrucao;

  logic        erro_endereco;
  logic        ocupado;

  logic [1:0]  estado_dbg;
  logic [3:0]  cont_dados_dbg;

  modport slave (
    input  busca_req, busca_end, dado_req, dado_escrita_en, dado_end,
           dado_wdata, mem_instrucao,
    output busca_ack, busca_dado, dado_ack, dado_rdata, mem_endereco,
           mem_dado_escrita, mem_leitura, mem_escrita, erro_endereco,
           ocupado, estado_dbg, cont_dados_dbg
  );

  modport master (
    output busca_req, busca_end, dado_req, dado_escrita_en, dado_end,
           dado_wdata, mem_instrucao,
    input  busca_ack, busca_dado, dado_ack, dado_rdata, mem_endereco,
           mem_dado_escrita, mem_leitura, mem_escrita, erro_endereco,
           ocupado, estado_dbg, cont_dados_dbg
  );
endinterface

// File: rtl/arbitro_memoria.sv
// Registered arbiter/sequencer granting fetch or load/store access to the
// single-port strobe memory, one access at a time.
module arbitro_memoria #(
  parameter int TAM_MEM      = 1024,
  parameter int LIMITE_DADOS = 4
) (
  input logic              clock,
  input logic              reset_n,
  arbitro_memoria_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ACESSO = 2'd1,
    LIBERA = 2'd2
  } estado_t;

  localparam logic [31:0] LIMITE_END = 32'(TAM_MEM);
  localparam logic [3:0]  LIMITE     = 4'(LIMITE_DADOS);

  estado_t     estado;
  logic [3:0]  cont_dados;
  logic        venc_busca;
  logic        venc_escrita;

  logic        ganha_busca;
  logic [31:0] end_venc;
  logic        fora;

  // Data has priority until it has starved a waiting fetch LIMITE times.
  always_comb begin
    ganha_busca = bus.busca_req && (!bus.dado_req || cont_dados == LIMITE);
    end_venc    = ganha_busca ? bus.busca_end : bus.dado_end;
    fora        = end_venc >= LIMITE_END;
  end

  assign bus.estado_dbg     = estado;
  assign bus.cont_dados_dbg = cont_dados;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado               <= OCIOSO;
      cont_dados           <= '0;
      venc_busca           <= 1'b0;
      venc_escrita         <= 1'b0;
      bus.busca_ack        <= 1'b0;
      bus.busca_dado       <= '0;
      bus.dado_ack         <= 1'b0;
      bus.dado_rdata       <= '0;
      bus.mem_endereco     <= '0;
      bus.mem_dado_escrita <= '0;
      bus.mem_leitura      <= 1'b0;
      bus.mem_escrita      <= 1'b0;
      bus.erro_endereco    <= 1'b0;
      bus.ocupado          <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.busca_req || bus.dado_req) begin
            venc_busca       <= ganha_busca;
            venc_escrita     <= !ganha_busca && bus.dado_escrita_en;
            bus.mem_endereco <= end_venc;
            bus.ocupado      <= 1'b1;
            if (!ganha_busca) bus.mem_dado_escrita <= bus.dado_wdata;

            if (ganha_busca) cont_dados <= '0;
            else if (bus.busca_req && cont_dados != LIMITE) cont_dados <= cont_dados + 4'd1;

            // Out-of-range accesses skip the memory and answer straight away.
            if (fora) begin
              estado            <= LIBERA;
              bus.erro_endereco <= 1'b1;
              if (ganha_busca) begin
                bus.busca_ack  <= 1'b1;
                bus.busca_dado <= '0;
              end else begin
                bus.dado_ack <= 1'b1;
                if (!bus.dado_escrita_en) bus.dado_rdata <= '0;
              end
            end else begin
              estado          <= ACESSO;
              bus.mem_leitura <= ganha_busca || !bus.dado_escrita_en;
              bus.mem_escrita <= !ganha_busca && bus.dado_escrita_en;
            end
          end
        end

        ACESSO: begin
          bus.mem_leitura <= 1'b0;
          bus.mem_escrita <= 1'b0;
          estado          <= LIBERA;
          if (venc_busca) begin
            bus.busca_ack  <= 1'b1;
            bus.busca_dado <= bus.mem_instrucao;
          end else begin
            bus.dado_ack <= 1'b1;
            if (!venc_escrita) bus.dado_rdata <= bus.mem_instrucao;
          end
        end

        LIBERA: begin
          bus.busca_ack     <= 1'b0;
          bus.dado_ack      <= 1'b0;
          bus.erro_endereco <= 1'b0;
          bus.ocupado       <= 1'b0;
          estado            <= OCIOSO;
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Randomized and directed bench for arbitro_memoria with a transaction-level
// reference model and a per-cycle output compare.
module tb_arbitro_memoria;
  localparam int TAM_MEM      = 1024;
  localparam int LIMITE_DADOS = 4;
  localparam int W            = 32;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  arbitro_memoria_if bus();

  arbitro_memoria #(.TAM_MEM(TAM_MEM), .LIMITE_DADOS(LIMITE_DADOS)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nome, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ini_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h5A00_0000 | 32'(i * 7);
  endfunction

  // ---------------- physical strobe memory ----------------
  logic [W-1:0] mem_fis [TAM_MEM];
  bit           escrito [TAM_MEM];
  int           idx_fis;

  always_comb begin
    idx_fis = int'(bus.mem_endereco[9:0]);
    if (bus.mem_leitura && bus.mem_endereco < 32'(TAM_MEM))
      bus.mem_instrucao = escrito[idx_fis] ? mem_fis[idx_fis] : ini_val(idx_fis);
    else
      bus.mem_instrucao = 32'hBAD0_0000 ^ bus.mem_endereco;
  end

  always @(posedge clock) begin
    if (bus.mem_escrita && bus.mem_endereco < 32'(TAM_MEM)) begin
      mem_fis[bus.mem_endereco[9:0]] <= bus.mem_dado_escrita;
      escrito[bus.mem_endereco[9:0]] <= 1'b1;
    end
  end

  // ---------------- reference model + compare ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [TAM_MEM];
  string        ordem = "";
  int           n_escr = 0;
  int           n_leit = 0;

  initial begin : compare
    int cyc, idle_from, g_cyc, cont, d;
    bit g_valid, g_fetch, g_write, g_oor, prev_str;
    bit x_str, x_ack, x_oc;
    logic [W-1:0] g_addr, g_wdata, g_rval, e_busca, e_rdata, e_end, popped;
    cyc = 0; idle_from = 0; g_cyc = 0; cont = 0;
    g_valid = 0; g_fetch = 0; g_write = 0; g_oor = 0; prev_str = 0;
    g_addr = '0; g_wdata = '0; g_rval = '0; e_busca = '0; e_rdata = '0; e_end = '0;
    for (int i = 0; i < TAM_MEM; i++) model_mem[i] = ini_val(i);
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (!reset_n) begin
        idle_from = 0; cont = 0; g_valid = 0; prev_str = 0;
        e_busca = '0; e_rdata = '0; e_end = '0;
        exp_q.delete();
        chk("rst_leitura", W'(bus.mem_leitura), 0);
        chk("rst_escrita", W'(bus.mem_escrita), 0);
        chk("rst_acks", W'({bus.busca_ack, bus.dado_ack, bus.erro_endereco, bus.ocupado}), 0);
        chk("rst_endereco", bus.mem_endereco, 0);
        chk("rst_rdata", bus.dado_rdata, 0);
        continue;
      end
      if (cyc >= idle_from && (bus.busca_req || bus.dado_req)) begin
        g_fetch = bus.busca_req && (!bus.dado_req || cont == LIMITE_DADOS);
        if (g_fetch) cont = 0;
        else if (bus.busca_req && cont < LIMITE_DADOS) cont++;
        g_addr  = g_fetch ? bus.busca_end : bus.dado_end;
        g_write = !g_fetch && bus.dado_escrita_en;
        g_oor   = g_addr >= 32'(TAM_MEM);
        if (!g_fetch) g_wdata = bus.dado_wdata;
        g_rval  = g_oor ? '0 : model_mem[g_addr[9:0]];
        g_cyc   = cyc;
        g_valid = 1;
        idle_from = cyc + (g_oor ? 2 : 3);
        e_end   = g_addr;
        if (!g_write) exp_q.push_back(g_rval);
      end
      d     = cyc - g_cyc;
      x_str = g_valid && !g_oor && d == 0;
      x_ack = g_valid && (g_oor ? d == 0 : d == 1);
      x_oc  = g_valid && (g_oor ? d == 0 : d <= 1);
      if (x_ack) begin
        if (g_fetch) e_busca = g_rval;
        else if (!g_write) e_rdata = g_rval;
        else if (!g_oor) model_mem[g_addr[9:0]] = g_wdata;
      end
      chk("mem_leitura", W'(bus.mem_leitura), W'(x_str && !g_write));
      chk("mem_escrita", W'(bus.mem_escrita), W'(x_str && g_write));
      chk("busca_ack", W'(bus.busca_ack), W'(x_ack && g_fetch));
      chk("dado_ack", W'(bus.dado_ack), W'(x_ack && !g_fetch));
      chk("erro_endereco", W'(bus.erro_endereco), W'(x_ack && g_oor));
      chk("ocupado", W'(bus.ocupado), W'(x_oc));
      chk("mem_endereco", bus.mem_endereco, e_end);
      chk("busca_dado", bus.busca_dado, e_busca);
      chk("dado_rdata", bus.dado_rdata, e_rdata);
      if (x_str && g_write) chk("mem_dado_escrita", bus.mem_dado_escrita, g_wdata);
      chk("strobe_excl", W'(bus.mem_leitura && bus.mem_escrita), 0);
      chk("strobe_consec", W'(prev_str && (bus.mem_leitura || bus.mem_escrita)), 0);
      prev_str = bus.mem_leitura || bus.mem_escrita;
      if (bus.mem_escrita) n_escr++;
      if (bus.mem_leitura) n_leit++;
      // scoreboard: every read ack carries the word queued at its grant
      if (bus.busca_ack || (bus.dado_ack && !bus.dado_escrita_en)) begin
        if (exp_q.size() == 0) chk("sb_queue_empty", 1, 0);
        else begin
          popped = exp_q.pop_front();
          chk("sb_read_word", bus.busca_ack ? bus.busca_dado : bus.dado_rdata, popped);
        end
      end
      if (bus.busca_ack) ordem = {ordem, "F"};
      if (bus.dado_ack)  ordem = {ordem, "D"};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic esperar_ack(input bit busca);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (busca ? bus.busca_ack : bus.dado_ack) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(busca ? "busca_ack_timeout" : "dado_ack_timeout", 0, 1);
  endtask

  task automatic do_busca(input logic [W-1:0] ende);
    @(negedge clock);
    bus.busca_end = ende;
    bus.busca_req = 1'b1;
    esperar_ack(1'b1);
    @(negedge clock);
    bus.busca_req = 1'b0;
  endtask

  task automatic do_dado(input bit escrita, input logic [W-1:0] ende, input logic [W-1:0] wd);
    @(negedge clock);
    bus.dado_escrita_en = escrita;
    bus.dado_end        = ende;
    bus.dado_wdata      = wd;
    bus.dado_req        = 1'b1;
    esperar_ack(1'b0);
    @(negedge clock);
    bus.dado_req = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_end();
    if ($urandom_range(0, 19) == 0) return 32'(TAM_MEM) + 32'($urandom_range(0, 7));
    return 32'($urandom_range(0, 63));
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    int s_escr, s_leit;
    bus.busca_req = 0; bus.busca_end = '0;
    bus.dado_req = 0; bus.dado_escrita_en = 0; bus.dado_end = '0; bus.dado_wdata = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_estado", W'(bus.estado_dbg), 0);
    chk("reset_cont", W'(bus.cont_dados_dbg), 0);
    chk("reset_busca_dado", bus.busca_dado, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // grant order under continuous contention
    @(negedge clock);
    bus.busca_end = 32'd7; bus.dado_end = 32'd3; bus.dado_escrita_en = 0;
    bus.busca_req = 1; bus.dado_req = 1;
    ordem = "";
    for (int i = 0; i < 200 && ordem.len() < 10; i++) begin
      @(posedge clock);
      #2;
    end
    @(negedge clock);
    bus.busca_req = 0; bus.dado_req = 0;
    chk("grant_order_DDDDFDDDDF", W'(ordem == "DDDDFDDDDF"), 1);
    repeat (3) @(posedge clock);

    // single load
    do_dado(1'b0, 32'd5, '0);
    chk("load5_word", bus.dado_rdata, 32'hDEADBEEF);

    // store then load back
    s_escr = n_escr; s_leit = n_leit;
    do_dado(1'b1, 32'd10, 32'h12345678);
    chk("store_one_pulse", W'(n_escr - s_escr), 1);
    chk("store_no_read", W'(n_leit - s_leit), 0);
    chk("store_keeps_rdata", bus.dado_rdata, 32'hDEADBEEF);
    do_dado(1'b0, 32'd10, '0);
    chk("load_after_store", bus.dado_rdata, 32'h12345678);

    // lone fetch granted on first idle sample
    @(negedge clock);
    bus.busca_end = 32'd33; bus.busca_req = 1;
    @(posedge clock);
    #1;
    chk("lone_fetch_strobe", W'(bus.mem_leitura), 1);
    chk("lone_fetch_addr", bus.mem_endereco, 32'd33);
    esperar_ack(1'b1);
    chk("lone_fetch_word", bus.busca_dado, 32'h5A00_0000 | 32'd231);
    @(negedge clock);
    bus.busca_req = 0;

    // out-of-range fetch
    @(negedge clock);
    bus.busca_end = 32'd1024; bus.busca_req = 1;
    @(posedge clock);
    #1;
    chk("oor_ack", W'(bus.busca_ack), 1);
    chk("oor_erro", W'(bus.erro_endereco), 1);
    chk("oor_no_strobe", W'(bus.mem_leitura || bus.mem_escrita), 0);
    chk("oor_busca_dado", bus.busca_dado, 0);
    @(negedge clock);
    bus.busca_req = 0;
    repeat (2) @(posedge clock);

    // reset during the access cycle of a store
    @(negedge clock);
    bus.dado_escrita_en = 1; bus.dado_end = 32'd20; bus.dado_wdata = 32'hCAFEF00D;
    bus.dado_req = 1;
    @(posedge clock);
    #2;
    chk("pre_reset_escrita", W'(bus.mem_escrita), 1);
    reset_n = 1'b0;
    bus.dado_req = 0;
    #1;
    chk("async_rst_escrita", W'(bus.mem_escrita), 0);
    chk("async_rst_ack", W'(bus.dado_ack), 0);
    chk("async_rst_ocupado", W'(bus.ocupado), 0);
    chk("async_rst_endereco", bus.mem_endereco, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    do_dado(1'b0, 32'd20, '0);
    chk("aborted_store_no_write", bus.dado_rdata, 32'h5A00_0000 | 32'd140);
    do_dado(1'b1, 32'd20, 32'hCAFEF00D);
    do_dado(1'b0, 32'd20, '0);
    chk("reissued_store", bus.dado_rdata, 32'hCAFEF00D);

    // randomized traffic from both requesters
    fork
      for (int i = 0; i < 100; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        do_busca(rand_end());
      end
      for (int j = 0; j < 100; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        do_dado(1'($urandom_range(0, 1)), rand_end(), $urandom);
      end
    join
    repeat (5) @(posedge clock);
    #1;
    chk("final_queue_empty", W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
